// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_STOP    = 2'd2
  } hz_state_e;

  localparam int MEMTO_DEFAULT = 255;
  localparam int CNT_W         = 16;
  localparam int TIMER_W       = 8;

  // Increment a statistics counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v != '1) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_timer.sv
// Counts consecutive data-memory wait cycles and flags when the count
// being written reaches the MEMTO limit.
module mem_wait_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MEMTO = MEMTO_DEFAULT
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic load,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  logic [TIMER_W-1:0] timer_q, timer_d;

  // Next timer value: clear wins, then load to one, then increment.
  always_comb begin
    timer_d = timer_q;
    if (clr) begin
      timer_d = '0;
    end else if (load) begin
      timer_d = TIMER_W'(1);
    end else if (inc && timer_q != '1) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  assign expired = (load || inc) && (timer_d >= TIMER_W'(MEMTO));

  // Timer register, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirect flushes,
// data-memory wait freezes with timeout, and halt handling.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEMTO = MEMTO_DEFAULT
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       rs1id,
  input  logic [4:0]       rs2id,
  input  logic             users1id,
  input  logic             users2id,
  input  logic [4:0]       destex,
  input  logic             memreadex,
  input  logic             redirectex,
  input  logic             dreq,
  input  logic             dready,
  input  logic             haltwb,
  output logic             pcwrite,
  output logic             ifidwrite,
  output logic             idexwrite,
  output logic             exmemwrite,
  output logic             ifidflush,
  output logic             idexbubble,
  output logic             memwbbubble,
  output logic             halted,
  output logic             memerr,
  output logic [CNT_W-1:0] luscnt,
  output logic [CNT_W-1:0] memwcnt
);

  hz_state_e        state_q, state_d;
  logic             halted_q, halted_d;
  logic             memerr_q, memerr_d;
  logic [CNT_W-1:0] luscnt_q, luscnt_d;
  logic [CNT_W-1:0] memwcnt_q, memwcnt_d;

  logic loaduse, memstall;
  logic tmr_load, tmr_inc, tmr_clr, tmr_expired;

  assign loaduse  = memreadex && (destex != 5'd0) &&
                    ((users1id && rs1id == destex) || (users2id && rs2id == destex));
  assign memstall = dreq && !dready;

  assign tmr_load = (state_q == ST_RUN) && memstall;
  assign tmr_inc  = (state_q == ST_MEMWAIT) && memstall;
  assign tmr_clr  = (state_q == ST_MEMWAIT) && !memstall;

  mem_wait_timer #(.MEMTO(MEMTO)) u_timer (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .load    (tmr_load),
    .inc     (tmr_inc),
    .clr     (tmr_clr),
    .expired (tmr_expired)
  );

  // Next state, sticky status, counters and stage-control decode.
  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    memerr_d    = memerr_q;
    luscnt_d    = luscnt_q;
    memwcnt_d   = memwcnt_q;
    pcwrite     = 1'b0;
    ifidwrite   = 1'b0;
    idexwrite   = 1'b0;
    exmemwrite  = 1'b0;
    ifidflush   = 1'b0;
    idexbubble  = 1'b0;
    memwbbubble = 1'b0;
    case (state_q)
      ST_RUN, ST_MEMWAIT: begin
        if (memstall) begin
          memwbbubble = 1'b1;
          memwcnt_d   = sat_inc(memwcnt_q);
          state_d     = ST_MEMWAIT;
        end else begin
          state_d    = ST_RUN;
          pcwrite    = 1'b1;
          ifidwrite  = 1'b1;
          idexwrite  = 1'b1;
          exmemwrite = 1'b1;
          if (redirectex) begin
            ifidflush  = 1'b1;
            idexbubble = 1'b1;
          end else if (loaduse) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            idexbubble = 1'b1;
            luscnt_d   = sat_inc(luscnt_q);
          end
        end
        if (haltwb) begin
          state_d  = ST_STOP;
          halted_d = 1'b1;
        end else if (tmr_expired) begin
          state_d  = ST_STOP;
          memerr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
    if (!RSTn) begin
      pcwrite     = 1'b0;
      ifidwrite   = 1'b0;
      idexwrite   = 1'b0;
      exmemwrite  = 1'b0;
      ifidflush   = 1'b0;
      idexbubble  = 1'b0;
      memwbbubble = 1'b0;
    end
  end

  // State, status and counter registers, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_RUN;
      halted_q  <= 1'b0;
      memerr_q  <= 1'b0;
      luscnt_q  <= '0;
      memwcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      memerr_q  <= memerr_d;
      luscnt_q  <= luscnt_d;
      memwcnt_q <= memwcnt_d;
    end
  end

  assign halted  = halted_q;
  assign memerr  = memerr_q;
  assign luscnt  = luscnt_q;
  assign memwcnt = memwcnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int MEMTO = 4;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [4:0]  rs1id = '0, rs2id = '0, destex = '0;
  logic        users1id = 1'b0, users2id = 1'b0, memreadex = 1'b0;
  logic        redirectex = 1'b0, dreq = 1'b0, dready = 1'b0, haltwb = 1'b0;
  logic        pcwrite, ifidwrite, idexwrite, exmemwrite;
  logic        ifidflush, idexbubble, memwbbubble, halted, memerr;
  logic [15:0] luscnt, memwcnt;
  logic [6:0]  ctl;

  int checkCount = 0;
  int errorCount = 0;

  // Model state: stopped flag, sticky causes, wait run length, counters.
  bit mStop, mHalted, mMemerr;
  int mWait, mLus, mMemw;

  hazard_ctrl #(.MEMTO(MEMTO)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .rs1id(rs1id), .rs2id(rs2id), .users1id(users1id), .users2id(users2id),
    .destex(destex), .memreadex(memreadex), .redirectex(redirectex),
    .dreq(dreq), .dready(dready), .haltwb(haltwb),
    .pcwrite(pcwrite), .ifidwrite(ifidwrite), .idexwrite(idexwrite),
    .exmemwrite(exmemwrite), .ifidflush(ifidflush), .idexbubble(idexbubble),
    .memwbbubble(memwbbubble), .halted(halted), .memerr(memerr),
    .luscnt(luscnt), .memwcnt(memwcnt)
  );

  assign ctl = {pcwrite, ifidwrite, idexwrite, exmemwrite, ifidflush, idexbubble, memwbbubble};

  always #5 CLK = ~CLK;

  // Count one comparison and report it when it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mStop = 0; mHalted = 0; mMemerr = 0; mWait = 0; mLus = 0; mMemw = 0;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                               input logic u2, input logic [4:0] dst, input logic mr,
                               input logic redir, input logic dq, input logic dr,
                               input logic hlt);
    bit lu, ms;
    logic [6:0] expCtl;
    @(posedge CLK);
    #1;
    rs1id = r1; rs2id = r2; users1id = u1; users2id = u2; destex = dst;
    memreadex = mr; redirectex = redir; dreq = dq; dready = dr; haltwb = hlt;
    lu = mr && dst != 0 && ((u1 && r1 == dst) || (u2 && r2 == dst));
    ms = dq && !dr;
    if (mStop)      expCtl = 7'b0000000;
    else if (ms)    expCtl = 7'b0000001;
    else if (redir) expCtl = 7'b1111110;
    else if (lu)    expCtl = 7'b0011010;
    else            expCtl = 7'b1111000;
    @(negedge CLK);
    checkOutput("ctl", ctl, expCtl);
    checkOutput("halted", halted, mHalted);
    checkOutput("memerr", memerr, mMemerr);
    checkOutput("luscnt", luscnt, mLus);
    checkOutput("memwcnt", memwcnt, mMemw);
    if (!mStop) begin
      if (ms) begin
        mWait++;
        if (mMemw < 65535) mMemw++;
      end else begin
        mWait = 0;
      end
      if (!ms && !redir && lu && mLus < 65535) mLus++;
      if (hlt) begin
        mStop = 1; mHalted = 1;
      end else if (ms && mWait >= MEMTO) begin
        mStop = 1; mMemerr = 1;
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset mid-cycle with hazard-free inputs and check everything is quiet.
  task automatic applyReset();
    @(posedge CLK);
    #1;
    rs1id = 0; rs2id = 0; users1id = 0; users2id = 0; destex = 0; memreadex = 0;
    redirectex = 0; dreq = 0; dready = 0; haltwb = 0;
    RSTn = 1'b0;
    #2;
    checkOutput("rst_ctl", ctl, 7'b0000000);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_memerr", memerr, 0);
    checkOutput("rst_luscnt", luscnt, 0);
    checkOutput("rst_memwcnt", memwcnt, 0);
    @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    modelReset();
  endtask

  initial begin
    int stopCycles;
    bit lowReady;
    logic [4:0] r1, r2, dst;
    modelReset();
    #3;
    checkOutput("por_ctl", ctl, 7'b0000000);
    checkOutput("por_luscnt", luscnt, 0);
    @(negedge CLK);
    RSTn = 1'b1;

    idleCycle();
    // Load x5 in EX, ID reads x5 through rs2.
    applyStimulus(0, 5, 0, 1, 5, 1, 0, 0, 0, 0);
    idleCycle();
    checkOutput("lus_after_loaduse", luscnt, 1);
    // Load to x0 never stalls.
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    idleCycle();
    checkOutput("lus_x0", luscnt, 1);
    // Three wait cycles then ready.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idleCycle();
    checkOutput("memw_three", memwcnt, 3);
    // Redirect together with a load-use hazard.
    applyStimulus(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    idleCycle();
    checkOutput("lus_redirect", luscnt, 1);

    // Memory timeout after MEMTO wait cycles.
    applyReset();
    for (int i = 0; i < MEMTO; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idleCycle();
    idleCycle();
    checkOutput("timeout_memerr", memerr, 1);
    checkOutput("timeout_ctl", ctl, 7'b0000000);
    checkOutput("timeout_memw", memwcnt, MEMTO);

    // Halt while waiting on memory, then reset out of STOP.
    applyReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idleCycle();
    idleCycle();
    checkOutput("halt_halted", halted, 1);
    checkOutput("halt_memerr", memerr, 0);
    applyReset();
    idleCycle();
    checkOutput("halt_cleared", halted, 0);
    checkOutput("run_resumed", ctl, 7'b1111000);

    // Randomized traffic with small register indices to provoke collisions.
    stopCycles = 0;
    for (int i = 0; i < 3000; i++) begin
      lowReady = ((i / 150) % 2) == 1;
      if ((mStop && stopCycles > 3) || $urandom_range(0, 299) == 0) begin
        applyReset();
        stopCycles = 0;
      end else begin
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        dst = 5'($urandom_range(0, 7));
        applyStimulus(r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dst,
                      1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                      1'($urandom_range(0, 1)),
                      lowReady ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 99) == 0);
        if (mStop) stopCycles++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEMTO, default 255, meaning max consecutive cycles spent waiting on data memory before error; legal range 1..255.
REQ-002 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 RSTn  in  1  reset; asynchronous assert, active-low.
REQ-004 rs1id, rs2id  in  5 each  source register indices of the instruction in ID.
REQ-005 users1id, users2id  in  1 each  ID instruction reads rs1 / rs2.
REQ-006 destex  in  5  destination index of the instruction in EX.
REQ-007 memreadex  in  1  EX instruction is a load.
REQ-008 redirectex  in  1  EX resolved a taken branch or jump; PC must load the target.
REQ-009 dreq  in  1  MEM stage holds a valid load/store.
REQ-010 dready  in  1  data memory completes the MEM access this cycle.
REQ-011 haltwb  in  1  halt instruction is in WB.
REQ-012 pcwrite, ifidwrite, idexwrite, exmemwrite  out  1 each  stage register write enables.
REQ-013 ifidflush, idexbubble, memwbbubble  out  1 each  insert NOP into IF/ID, ID/EX, MEM/WB.
REQ-014 halted  out  1  core stopped by halt; memerr  out  1  core stopped by memory timeout.
REQ-015 luscnt  out  16  load-use bubble cycles; memwcnt  out  16  memory wait cycles.

Function
REQ-016 FSM states: RUN, MEMWAIT, STOP; encoding per shared package.
REQ-017 loaduse = memreadex && destex!=0 && ((users1id && rs1id==destex) || (users2id && rs2id==destex)).
REQ-018 memstall = dreq && !dready.
REQ-019 RUN, memstall=0, redirectex=1: pcwrite=1, ifidflush=1, idexbubble=1, other enables 1; loaduse ignored.
REQ-020 RUN, memstall=0, redirectex=0, loaduse=1: pcwrite=0, ifidwrite=0, idexbubble=1, idexwrite=1, exmemwrite=1; luscnt increments.
REQ-021 RUN with no hazard: all write enables 1, all flush/bubble 0.
REQ-022 memstall in RUN or MEMWAIT: pcwrite=ifidwrite=idexwrite=exmemwrite=0, memwbbubble=1; redirect and loaduse suppressed this cycle (their sources stay frozen and take effect after release); memwcnt increments.
REQ-023 RUN -> MEMWAIT when memstall; wait timer loads 1.
REQ-024 MEMWAIT -> RUN in the cycle dready=1; that cycle is unfrozen and REQ-019..021 apply; timer clears.
REQ-025 MEMWAIT, dready=0: timer increments; when timer reaches MEMTO, next state STOP with memerr=1.
REQ-026 haltwb=1 in RUN or MEMWAIT: next state STOP with halted=1; haltwb takes priority over the timeout in the same cycle.
REQ-027 STOP: all write enables 0, flush/bubble 0, halted/memerr held; exit only by reset.
REQ-028 luscnt, memwcnt saturate at 16'hFFFF; they do not count in STOP.
REQ-029 memstall and loaduse together: memstall wins; luscnt not incremented that cycle.

Reset
REQ-030 RSTn=0 asynchronously forces state=RUN, timer=0, luscnt=memwcnt=0, halted=memerr=0.
REQ-031 While RSTn=0: all write enables 0, all flush/bubble 0.
REQ-032 Reset during MEMWAIT or STOP discards all state; first cycle after release behaves as RUN.

Structure
REQ-033 Shared package holds the state typedef, MEMTO default, and counter width constant (16).
REQ-034 One sub-module, mem_wait_timer, holds the load/increment/clear timer and compare-to-MEMTO; everything else is inline.
REQ-035 Output decode is combinational from state and inputs; only state, timer, counters, halted, and memerr are registered.

Verification
REQ-036 Load x5 in EX, ID uses rs2=x5 with users2id=1 -> one cycle pcwrite=0, ifidwrite=0, idexbubble=1; luscnt 0->1.
REQ-037 destex=0, memreadex=1, rs1id=0 -> no stall; luscnt unchanged.
REQ-038 dreq=1 with dready low for 3 cycles then high -> 3 frozen cycles with memwbbubble=1; memwcnt=3; RUN on the 4th cycle.
REQ-039 MEMTO=4, dreq=1, dready stuck low -> STOP after the 4th wait cycle; memerr=1; all enables 0 thereafter.
REQ-040 redirectex=1 and loaduse=1 together -> ifidflush=1, idexbubble=1, pcwrite=1; luscnt unchanged.
REQ-041 haltwb=1 during MEMWAIT, then RSTn pulsed low mid-STOP -> halted=1 and enables 0; after reset, halted=0 and RUN resumes.
